// File: rtl/log_mag_expand.sv
// log_mag_expand: rebuilds a magnitude-squared value from its log2 form and
// optionally takes its integer square root.
//
// A log word is integer part log_int plus the 8 mantissa bits just below the
// leading one (log_frac). It is expanded to a 33-bit linear value. Values with
// log_int above 32 do not fit and saturate to all ones with sat set.
//
// Build option: define LOG_MAG_EXPAND_SQRT_EN to include the bit-serial
// square-root stage (IDLE->EXPAND->SQRT x17->DONE, 19 edges accept to result).
// Without it the flow is IDLE->EXPAND->DONE (2 edges) and mag is tied to zero.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Once out_valid is raised it stays high, and the result stays stable,
// until the edge that sees out_ready high. in_ready is high only in IDLE.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake for log_int[5:0], log_frac[7:0]
//   out_valid/out_ready output handshake for mag_sqr[32:0], mag[16:0], sat
module log_mag_expand (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  log_int,
  input  logic [7:0]  log_frac,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:0] mag_sqr,
  output logic [16:0] mag,
  output logic        sat
);

`ifdef LOG_MAG_EXPAND_SQRT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, SQRT = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t      state_q, state_d;
  logic [5:0]  log_int_q;
  logic [7:0]  log_frac_q;
  logic [32:0] mag_sqr_q, mag_sqr_d;
  logic        sat_q, sat_d;
  logic [32:0] frac_ext;

`ifdef LOG_MAG_EXPAND_SQRT_EN
  logic [4:0]  iter_q;
  logic [33:0] rad_q;      // radicand, consumed two bits per step from the top
  logic [20:0] rem_q, rem_d;
  logic [15:0] root_q, root_d;
  logic [16:0] mag_q;
  logic [20:0] rem_t, trial, diff;
  logic        ge;
`endif

  // Expansion of the latched log word into a linear value.
  always_comb begin
    frac_ext  = {25'd0, log_frac_q};
    mag_sqr_d = '1;
    sat_d     = 1'b1;
    if (log_int_q == 6'd0) begin
      mag_sqr_d = 33'd1;
      sat_d     = 1'b0;
    end else if (log_int_q <= 6'd8) begin
      // Only the top log_int mantissa bits survive above the binary point.
      mag_sqr_d = (33'd1 << log_int_q) | (frac_ext >> (6'd8 - log_int_q));
      sat_d     = 1'b0;
    end else if (log_int_q <= 6'd32) begin
      mag_sqr_d = (33'd1 << log_int_q) | (frac_ext << (log_int_q - 6'd8));
      sat_d     = 1'b0;
    end
  end

`ifdef LOG_MAG_EXPAND_SQRT_EN
  // One restoring step: bring down the next radicand pair and try appending a
  // 1 to the partial root (trial = 4*root + 1).
  always_comb begin
    rem_t  = (rem_q << 2) | {19'd0, rad_q[33:32]};
    trial  = ({5'd0, root_q} << 2) | 21'd1;
    ge     = (rem_t >= trial);
    diff   = rem_t - trial;
    rem_d  = ge ? diff : rem_t;
    root_d = (root_q << 1) | {15'd0, ge};
  end
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (in_valid) state_d = EXPAND;
`ifdef LOG_MAG_EXPAND_SQRT_EN
      EXPAND: state_d = SQRT;
      SQRT:   if (iter_q == 5'd16) state_d = DONE;
`else
      EXPAND: state_d = DONE;
`endif
      DONE:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      log_int_q  <= '0;
      log_frac_q <= '0;
      mag_sqr_q  <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        log_int_q  <= log_int;
        log_frac_q <= log_frac;
      end
      if (state_q == EXPAND) begin
        mag_sqr_q <= mag_sqr_d;
        sat_q     <= sat_d;
      end
    end
  end

`ifdef LOG_MAG_EXPAND_SQRT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_q <= '0;
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      mag_q  <= '0;
    end else if (state_q == EXPAND) begin
      // Load straight from the expander so SQRT starts on the next edge.
      iter_q <= '0;
      rad_q  <= {1'b0, mag_sqr_d};
      rem_q  <= '0;
      root_q <= '0;
    end else if (state_q == SQRT) begin
      rad_q  <= rad_q << 2;
      rem_q  <= rem_d;
      root_q <= root_d;
      if (iter_q == 5'd16) begin
        iter_q <= '0;
        // mag only changes here so it keeps the previous result until then.
        mag_q  <= {root_q, ge};
      end else begin
        iter_q <= iter_q + 5'd1;
      end
    end
  end

  assign mag = mag_q;
`else
  assign mag = '0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign mag_sqr   = mag_sqr_q;
  assign sat       = sat_q;

endmodule
